pipe_ctrl_reg: RTL and testbench
================================

# pipe_ctrl_reg

Parametrised pipeline-stage control register with elastic valid/ready handshake, an optional 2-entry skid buffer, synchronous flush-to-bubble, and a saturating back-pressure counter. It sits between any two pipeline stages, such as ID→EX, EX→MEM or MEM→WB. It carries a packed control-signal word and supports both stalls and flushes, which the earlier fixed-field, flush-only stage registers do not.

## Interface
Parameters:
- WIDTH, 8, width of packed control word
- FLUSH_VAL, {WIDTH{1'b0}}, value loaded into all data registers on reset or flush
- SKID, 1, 1 = 2-entry skid buffer (registered in_ready); 0 = single register (combinational in_ready)
- CNT_W, 16, width of stall counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  synchronous flush, active high
- in_valid  in  1  upstream word valid
- in_ready  out  1  stage can accept a word this cycle
- in_data  in  WIDTH  upstream control word
- out_valid  out  1  stage holds a valid word
- out_ready  in  1  downstream accepts this cycle
- out_data  out  WIDTH  held control word
- occupancy  out  2  words held (0..2; max 1 when SKID=0)
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Internal state: main register M (m_valid, m_data); skid register S (s_valid, s_data), present only when SKID=1.
- Definitions: accept = in_valid & in_ready; pop = out_valid & out_ready.
- Output mapping: out_valid = m_valid; out_data = m_data; occupancy = m_valid + s_valid.
- in_ready:
  - SKID=1: !s_valid & !flush. Depends only on registered state and flush.
  - SKID=0: (!m_valid | out_ready) & !flush.
- SKID=1 update, when not flushing:
  - s_valid & pop: M←S, S empties. No accept is possible in this case.
  - !s_valid & (pop | !m_valid): M←in_data if accept, else m_valid←0.
  - !s_valid & m_valid & !pop & accept: S←in_data, M holds.
  - Otherwise: hold.
- SKID=0 update: on accept, M←in_data. On pop without accept, m_valid←0. Otherwise hold.
- Data registers of empty entries hold their last value. The value is don't-care but must not be X after reset.
- Flush:
  - m_valid, s_valid←0; m_data, s_data←FLUSH_VAL.
  - in_valid/in_data are discarded because in_ready=0.
  - A pop in the flush cycle is a completed transfer; downstream legitimately consumed the word.
- Flush and reset: rst_n=0 overrides flush.
- stall_cnt:
  - Increments each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W−1.
  - Unaffected by flush; cleared only by reset.

## Timing
- Reset values, one cycle after clk edge with rst_n=0: out_valid=0, out_data=FLUSH_VAL, occupancy=0, stall_cnt=0. in_ready becomes 1 once reset deasserts, provided flush=0.
- Latency: word accepted at edge N is on out_data/out_valid after edge N, i.e. visible in cycle N+1.
- Throughput: 1 word/cycle sustained when out_ready=1.
- SKID=1 back-pressure:
  - After out_ready drops, one more word is absorbed into S.
  - in_ready falls the cycle after S fills.
  - in_ready rises the cycle after S drains.
  - No combinational path from out_ready to in_ready.
- Ordering: words exit strictly in acceptance order. No duplication; no loss except by flush.
- Simultaneous events:
  - Accept and pop with S empty and M valid: M replaced by the new word, occupancy stays 1.
  - Flush with pop: the pop completes, the stage empties.
  - Reset mid-transfer: all words dropped, stall_cnt cleared.

## Test plan
- Reset/idle: hold rst_n=0 two cycles with flush=1 and in_valid=1 → out_valid=0, out_data=0x00, occupancy=0, stall_cnt=0. After release, in_ready=1.
- Streaming, SKID=1, out_ready=1: drive 0x11,0x22,0x33 on consecutive cycles → out_data 0x11,0x22,0x33 on the next three consecutive cycles, occupancy never exceeds 1.
- Back-pressure:
  - Stream 0xA1..0xA4 with out_ready=0 from the cycle 0xA1 appears.
  - Expect 0xA2 absorbed into S, occupancy=2, in_ready=0, 0xA3 held upstream.
  - After 5 stalled cycles stall_cnt=5; raising out_ready yields 0xA1,0xA2,0xA3,0xA4 in order with no gaps.
- Flush: with occupancy=2 (0xB1,0xB2) and in_valid=1 with 0xB3, pulse flush one cycle → next cycle out_valid=0, occupancy=0, out_data=FLUSH_VAL, 0xB3 never appears. stall_cnt is retained.
- SKID=0 build: with out_valid=1 and out_ready=0, in_ready=0 in the same cycle. Raising out_ready raises in_ready combinationally; accept+pop in that cycle replaces the word with occupancy=1.
- Saturation: CNT_W=4, stall 20 cycles → stall_cnt stops at 15. Reset returns it to 0.

Source files
------------

// File: rtl/pipe_ctrl_reg.sv
// Pipeline-stage control register: elastic valid/ready handshake, optional
// 2-entry skid buffer, synchronous flush-to-bubble and a saturating stall counter.
module pipe_ctrl_reg #(
  parameter int unsigned             WIDTH     = 8,
  parameter logic [WIDTH-1:0]        FLUSH_VAL = {WIDTH{1'b0}},
  parameter bit                      SKID      = 1'b1,
  parameter int unsigned             CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q,  m_data_d;
  logic             s_valid_q, s_valid_d;
  logic [WIDTH-1:0] s_data_q,  s_data_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             accept, pop;

  // With the skid entry, in_ready is built from registers only, so out_ready
  // never ripples upstream through this stage.
  assign in_ready  = SKID ? (!s_valid_q && !flush)
                          : ((!m_valid_q || out_ready) && !flush);
  assign accept    = in_valid && in_ready;
  assign pop       = m_valid_q && out_ready;

  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;
  assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};
  assign stall_cnt = cnt_q;

  always_comb begin
    // NOTE: every next-state signal gets a hold default first, so no path
    // through the branches below can leave one unassigned and infer a latch.
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    cnt_d     = cnt_q;

    if (flush) begin
      m_valid_d = 1'b0;
      m_data_d  = FLUSH_VAL;
      s_valid_d = 1'b0;
      s_data_d  = FLUSH_VAL;
    end else if (SKID) begin
      if (s_valid_q && pop) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end else if (!s_valid_q && (pop || !m_valid_q)) begin
        m_valid_d = accept;
        if (accept) m_data_d = in_data;
      end else if (!s_valid_q && m_valid_q && accept) begin
        s_valid_d = 1'b1;
        s_data_d  = in_data;
      end
    end else begin
      if (accept) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data;
      end else if (pop) begin
        m_valid_d = 1'b0;
      end
    end

    // Counts stalled cycles regardless of flush; only reset clears it.
    if (m_valid_q && !out_ready && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: data registers are reset too, so an empty entry never shows X
    // on out_data; state is updated with non-blocking assignments only.
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= FLUSH_VAL;
      s_valid_q <= 1'b0;
      s_data_q  <= FLUSH_VAL;
      cnt_q     <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_reg.sv
// Directed bench for pipe_ctrl_reg: skid, no-skid and 4-bit-counter instances
// share one stimulus stream; each phase checks the instance it targets.
module tb_pipe_ctrl_reg;

  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, out_ready;
  logic [7:0] in_data;

  logic        sk_in_ready, sk_out_valid;
  logic [7:0]  sk_out_data;
  logic [1:0]  sk_occ;
  logic [15:0] sk_cnt;

  logic        ns_in_ready, ns_out_valid;
  logic [7:0]  ns_out_data;
  logic [1:0]  ns_occ;
  logic [15:0] ns_cnt;

  logic        st_in_ready, st_out_valid;
  logic [7:0]  st_out_data;
  logic [1:0]  st_occ;
  logic [3:0]  st_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl_reg #(.WIDTH(8), .SKID(1'b1), .CNT_W(16)) u_skid (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(sk_in_ready), .in_data(in_data), .out_valid(sk_out_valid),
    .out_ready(out_ready), .out_data(sk_out_data), .occupancy(sk_occ),
    .stall_cnt(sk_cnt));

  pipe_ctrl_reg #(.WIDTH(8), .SKID(1'b0), .CNT_W(16)) u_noskid (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(ns_in_ready), .in_data(in_data), .out_valid(ns_out_valid),
    .out_ready(out_ready), .out_data(ns_out_data), .occupancy(ns_occ),
    .stall_cnt(ns_cnt));

  pipe_ctrl_reg #(.WIDTH(8), .SKID(1'b1), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(st_in_ready), .in_data(in_data), .out_valid(st_out_valid),
    .out_ready(out_ready), .out_data(st_out_data), .occupancy(st_occ),
    .stall_cnt(st_cnt));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b1; in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b0;
    #1;

    // Reset dominates flush and incoming words.
    step(2);
    check("rst_out_valid", 32'(sk_out_valid), 32'd0);
    check("rst_out_data",  32'(sk_out_data),  32'h00);
    check("rst_occupancy", 32'(sk_occ),       32'd0);
    check("rst_stall_cnt", 32'(sk_cnt),       32'd0);
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_in_ready",    32'(sk_in_ready), 32'd1);
    check("rst_ns_in_ready", 32'(ns_in_ready), 32'd1);

    // Streaming at full rate.
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 8'h11; step();
    check("stream_d0", 32'(sk_out_data), 32'h11);
    check("stream_v0", 32'(sk_out_valid), 32'd1);
    check("stream_o0", 32'(sk_occ), 32'd1);
    in_data = 8'h22; step();
    check("stream_d1", 32'(sk_out_data), 32'h22);
    check("stream_o1", 32'(sk_occ), 32'd1);
    in_data = 8'h33; step();
    check("stream_d2", 32'(sk_out_data), 32'h33);
    check("stream_o2", 32'(sk_occ), 32'd1);
    in_valid = 1'b0; step();
    check("stream_drain", 32'(sk_out_valid), 32'd0);

    // Back-pressure into the skid entry.
    in_valid = 1'b1; in_data = 8'hA1; step();
    out_ready = 1'b0; in_data = 8'hA2;
    #1;
    check("bp_in_ready_pre", 32'(sk_in_ready), 32'd1);
    step();
    in_data = 8'hA3;
    #1;
    check("bp_occ2",     32'(sk_occ),      32'd2);
    check("bp_in_ready", 32'(sk_in_ready), 32'd0);
    check("bp_hold_A1",  32'(sk_out_data), 32'hA1);
    step(4);
    check("bp_stall5", 32'(sk_cnt), 32'd5);
    check("bp_out_A1", 32'(sk_out_data), 32'hA1);
    out_ready = 1'b1; step();
    check("bp_out_A2", 32'(sk_out_data), 32'hA2);
    check("bp_v_A2",   32'(sk_out_valid), 32'd1);
    check("bp_rdy_back", 32'(sk_in_ready), 32'd1);
    step();
    check("bp_out_A3", 32'(sk_out_data), 32'hA3);
    in_data = 8'hA4; step();
    check("bp_out_A4", 32'(sk_out_data), 32'hA4);
    check("bp_v_A4",   32'(sk_out_valid), 32'd1);
    in_valid = 1'b0; step();
    check("bp_empty",  32'(sk_out_valid), 32'd0);
    check("bp_cnt_kept", 32'(sk_cnt), 32'd5);

    // Flush with both entries full: B1 in M, B2 in S, B3 offered.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hB1; step();
    in_data = 8'hB2; step();
    check("fl_occ2", 32'(sk_occ), 32'd2);
    in_data = 8'hB3; flush = 1'b1;
    #1;
    check("fl_in_ready", 32'(sk_in_ready), 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", 32'(sk_out_valid), 32'd0);
    check("fl_occ0",      32'(sk_occ),       32'd0);
    check("fl_out_data",  32'(sk_out_data),  32'h00);
    check("fl_cnt_kept",  32'(sk_cnt),       32'd7);
    out_ready = 1'b1; step(2);
    check("fl_no_B3", 32'(sk_out_valid), 32'd0);

    // No-skid variant: combinational in_ready from out_ready.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hC1; step();
    in_data = 8'hC2;
    #1;
    check("ns_out_C1",     32'(ns_out_data), 32'hC1);
    check("ns_in_ready_0", 32'(ns_in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    check("ns_in_ready_1", 32'(ns_in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("ns_out_C2", 32'(ns_out_data), 32'hC2);
    check("ns_occ1",   32'(ns_occ),      32'd1);
    check("ns_cnt0",   32'(ns_cnt),      32'd0);

    // Counter saturation on a 4-bit instance.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hD1; step();
    in_valid = 1'b0;
    step(20);
    check("sat_cnt15",   32'(st_cnt), 32'd15);
    check("sat_wide20",  32'(sk_cnt), 32'd20);
    check("sat_out_D1",  32'(st_out_data), 32'hD1);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check("sat_rst_cnt", 32'(st_cnt), 32'd0);
    check("sat_rst_v",   32'(st_out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
